// File: rtl/sbus_pkg.sv
// Shared types and helpers for the MBOX-side SBUS memory-cycle sequencer.
package sbus_pkg;

   localparam int ADR_W_DEF = 22;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_ACK,
      DATA,
      DONE
   } sbus_state_t;

   typedef logic [1:0] word_idx_t;

   // First set bit of mask scanning upward from 'from' (inclusive), wrapping 3->0.
   function automatic word_idx_t next_word(input logic [3:0] mask, input word_idx_t from);
      word_idx_t idx;
      next_word = from;
      for (int k = 3; k >= 0; k--) begin
         idx = from + word_idx_t'(k);
         if (mask[idx]) next_word = idx;
      end
   endfunction

endpackage

// File: rtl/sbus_tmo_ctr.sv
// Saturating no-response timer; tc flags the LIMIT-th enabled cycle since the last clear.
module sbus_tmo_ctr #(
   parameter int W     = 6,
   parameter int LIMIT = 63
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (en && (cnt != W'(LIMIT))) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt >= W'(LIMIT - 1));

endmodule

// File: rtl/sbus_mem_ctl.sv
// Sequences one SBUS quadword memory cycle for the MBOX: start, acknowledge,
// per-word data transfer, timeout (NXM) and error reporting.
module sbus_mem_ctl
   import sbus_pkg::*;
#(
   parameter int ADR_W    = ADR_W_DEF,
   parameter int ACK_TMO  = 63,
   parameter int DATA_TMO = 63
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic             req_wr,
   input  logic [ADR_W-1:0] req_adr,
   input  logic [3:0]       req_rq,
   output logic             req_ack,
   output logic             adr_hold,
   output logic             start_a,
   output logic             start_b,
   output logic [3:0]       rq,
   output logic             rd_rq,
   output logic             wr_rq,
   output logic             data_to_mem,
   output logic             dv_a_out,
   output logic             dv_b_out,
   input  logic             ackn_a,
   input  logic             dv_a_in,
   input  logic             dv_b_in,
   input  logic             sb_error,
   input  logic             sb_adr_par_err,
   output logic             word_stb,
   output logic [1:0]       word_idx,
   output logic             done,
   output logic             nxm,
   output logic             mem_err
);

   localparam int TMR_W = $clog2(((ACK_TMO > DATA_TMO) ? ACK_TMO : DATA_TMO) + 1);

   sbus_state_t state, state_nxt;
   logic        wr_q;
   logic        adr0_q;
   logic [3:0]  rq_q;
   logic [3:0]  pend;
   logic [3:0]  pend_left;
   logic [3:0]  rq_eff;
   word_idx_t   cur_idx;
   logic        ack_clr, ack_en, ack_tc;
   logic        data_clr, data_en, data_tc;
   logic        take_word, tmo_hit, par_wrong;
   logic        unused_adr;

   // Only the quadword word offset matters here; the full PMA goes out on the address path.
   assign unused_adr = ^req_adr[ADR_W-1:2];
   assign rq_eff     = (req_rq == 4'b0000) ? 4'b1111 : req_rq;
   assign pend_left  = pend & ~(4'b0001 << cur_idx);

   sbus_tmo_ctr #(.W(TMR_W), .LIMIT(ACK_TMO)) ack_tmr (
      .clk   (clk),
      .reset (reset),
      .clr   (ack_clr),
      .en    (ack_en),
      .tc    (ack_tc)
   );

   sbus_tmo_ctr #(.W(TMR_W), .LIMIT(DATA_TMO)) data_tmr (
      .clk   (clk),
      .reset (reset),
      .clr   (data_clr),
      .en    (data_en),
      .tc    (data_tc)
   );

   always_comb begin
      state_nxt   = state;
      req_ack     = 1'b0;
      adr_hold    = 1'b0;
      start_a     = 1'b0;
      start_b     = 1'b0;
      rq          = 4'b0000;
      rd_rq       = 1'b0;
      wr_rq       = 1'b0;
      data_to_mem = 1'b0;
      dv_a_out    = 1'b0;
      dv_b_out    = 1'b0;
      word_stb    = 1'b0;
      word_idx    = 2'd0;
      done        = 1'b0;
      ack_clr     = 1'b0;
      ack_en      = 1'b0;
      data_clr    = 1'b0;
      data_en     = 1'b0;
      take_word   = 1'b0;
      tmo_hit     = 1'b0;
      par_wrong   = 1'b0;

      if (state == START || state == WAIT_ACK || state == DATA) begin
         adr_hold = 1'b1;
         rq       = rq_q;
         rd_rq    = ~wr_q;
         wr_rq    = wr_q;
      end

      case (state)
         IDLE: begin
            if (req) begin
               req_ack   = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            start_a   = ~adr0_q;
            start_b   = adr0_q;
            ack_clr   = 1'b1;
            state_nxt = WAIT_ACK;
         end
         // Address parity abort beats acknowledge, which beats the timeout.
         WAIT_ACK: begin
            ack_en = 1'b1;
            if (sb_adr_par_err) begin
               state_nxt = DONE;
            end else if (ackn_a) begin
               data_clr  = 1'b1;
               state_nxt = DATA;
            end else if (ack_tc) begin
               tmo_hit   = 1'b1;
               state_nxt = DONE;
            end
         end
         DATA: begin
            data_to_mem = wr_q;
            if (wr_q) begin
               take_word = 1'b1;
               dv_a_out  = ~cur_idx[0];
               dv_b_out  = cur_idx[0];
            end else if (dv_a_in || dv_b_in) begin
               take_word = 1'b1;
               par_wrong = cur_idx[0] ? dv_a_in : dv_b_in;
            end
            if (take_word) begin
               word_stb = 1'b1;
               word_idx = cur_idx;
               data_clr = 1'b1;
               if (pend_left == 4'b0000) state_nxt = DONE;
            end else begin
               data_en = 1'b1;
               if (data_tc) begin
                  tmo_hit   = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         wr_q    <= 1'b0;
         adr0_q  <= 1'b0;
         rq_q    <= 4'b0000;
         pend    <= 4'b0000;
         cur_idx <= 2'd0;
         nxm     <= 1'b0;
         mem_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (req_ack) begin
            wr_q    <= req_wr;
            adr0_q  <= req_adr[0];
            rq_q    <= rq_eff;
            pend    <= rq_eff;
            cur_idx <= next_word(rq_eff, req_adr[1:0]);
            nxm     <= 1'b0;
            mem_err <= 1'b0;
         end else begin
            if (take_word) begin
               pend    <= pend_left;
               cur_idx <= next_word(pend_left, cur_idx + 2'd1);
            end
            if (tmo_hit) nxm <= 1'b1;
            if ((state != IDLE) && (sb_error || sb_adr_par_err || par_wrong)) mem_err <= 1'b1;
         end
      end
   end

endmodule
